// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - physical-register freelist with committed-head checkpoint for one-cycle recovery
module freelist_ckpt #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int PIDX_W    = 6,
    parameter int ALLOC_W   = 4,
    parameter int RLS_W     = 4,
    parameter int CMT_W     = $clog2(ALLOC_W * 2)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ALLOC_W-1:0]        io_req,
    output logic [ALLOC_W*PIDX_W-1:0] io_pidx,
    output logic [ALLOC_W-1:0]        io_pvld,
    output logic                      io_busy,
    input  logic [RLS_W-1:0]          io_rls,
    input  logic [RLS_W*PIDX_W-1:0]   io_rls_pidx,
    input  logic [CMT_W-1:0]          io_cmt_cnt,
    input  logic                      io_recover,
    output logic [PIDX_W:0]           io_free_cnt,
    output logic                      io_err
);
    localparam int PTR_W = PIDX_W + 1;

    logic [PIDX_W-1:0] entries [NUM_PREGS];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  cmt_head;
    logic              err;

    logic [PTR_W-1:0]  free_cnt;
    logic [PTR_W-1:0]  alloc_cnt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rls_cnt;
    logic [PTR_W-1:0]  rls_off [RLS_W];
    logic [RLS_W-1:0]  rls_ok;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  in_flight;
    logic [PTR_W:0]    free_after_rls;
    logic              rls_ovf;
    logic              cmt_ovf;

    // Extra wrap bit lets tail - head distinguish a full queue from an empty one.
    assign free_cnt    = tail - head;
    assign io_free_cnt = free_cnt;
    assign io_busy     = (free_cnt < PTR_W'(ALLOC_W)) | io_recover;
    assign io_err      = err;

    always_comb begin
        alloc_cnt = '0;
        rd_ptr    = '0;
        io_pidx   = '0;
        io_pvld   = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            rd_ptr = head + alloc_cnt;
            io_pidx[i*PIDX_W +: PIDX_W] = entries[rd_ptr[PIDX_W-1:0]];
            io_pvld[i] = io_req[i] & ~io_busy;
            alloc_cnt  = alloc_cnt + PTR_W'(io_req[i]);
        end
    end

    // Releases of p0 are dropped; the surviving lanes pack densely from tail.
    always_comb begin
        rls_cnt = '0;
        rls_ok  = '0;
        for (int j = 0; j < RLS_W; j++) begin
            rls_ok[j]  = io_rls[j] & (io_rls_pidx[j*PIDX_W +: PIDX_W] != '0);
            rls_off[j] = tail + rls_cnt;
            rls_cnt    = rls_cnt + PTR_W'(rls_ok[j]);
        end
    end

    always_comb begin
        head_next = head;
        if (io_recover) begin
            head_next = cmt_head + PTR_W'(io_cmt_cnt);
        end else if (!io_busy) begin
            head_next = head + alloc_cnt;
        end
        in_flight      = head - cmt_head;
        cmt_ovf        = PTR_W'(io_cmt_cnt) > in_flight;
        free_after_rls = {1'b0, free_cnt} + {1'b0, rls_cnt};
        rls_ovf        = free_after_rls > (PTR_W + 1)'(NUM_PREGS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= '0;
            cmt_head <= '0;
            tail     <= PTR_W'(NUM_PREGS - NUM_ARCH);
            err      <= 1'b0;
            for (int i = 0; i < NUM_PREGS; i++) begin
                entries[i] <= (i < NUM_PREGS - NUM_ARCH) ? PIDX_W'(NUM_ARCH + i) : '0;
            end
        end else begin
            head     <= head_next;
            tail     <= tail + rls_cnt;
            cmt_head <= cmt_head + PTR_W'(io_cmt_cnt);
            if (rls_ovf || cmt_ovf) begin
                err <= 1'b1;
            end
            for (int j = 0; j < RLS_W; j++) begin
                if (rls_ok[j]) begin
                    entries[rls_off[j][PIDX_W-1:0]] <= io_rls_pidx[j*PIDX_W +: PIDX_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - randomized and directed bench for freelist_ckpt against a queue model
module tb_freelist_ckpt;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [23:0] pidx;
    logic [3:0]  pvld;
    logic        busy;
    logic [3:0]  rls = '0;
    logic [23:0] rls_pidx = '0;
    logic [2:0]  cmt_cnt = '0;
    logic        recover = 1'b0;
    logic [6:0]  free_cnt;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: unbounded integer pointers over a 64-slot ring.
    int         m_head, m_tail, m_cmt;
    bit         m_err;
    logic [5:0] m_mem [64];

    freelist_ckpt dut (
        .clock(clock), .reset(reset), .io_req(req), .io_pidx(pidx), .io_pvld(pvld),
        .io_busy(busy), .io_rls(rls), .io_rls_pidx(rls_pidx), .io_cmt_cnt(cmt_cnt),
        .io_recover(recover), .io_free_cnt(free_cnt), .io_err(err)
    );

    always #5 clock = ~clock;

    function automatic int m_free();
        return m_tail - m_head;
    endfunction

    function automatic logic m_busy();
        return (m_free() < 4) || recover;
    endfunction

    function automatic logic [5:0] m_lane(int k);
        return m_mem[(m_head + k) % 64];
    endfunction

    task automatic model_reset();
        m_head = 0;
        m_cmt  = 0;
        m_tail = 32;
        m_err  = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = (i < 32) ? 6'(32 + i) : 6'd0;
    endtask

    task automatic tick();
        int   n;
        int   c;
        logic bsy;
        bsy = m_busy();
        c   = int'(cmt_cnt);
        n   = 0;
        for (int j = 0; j < 4; j++) begin
            if (rls[j] && rls_pidx[j*6 +: 6] != 6'd0) begin
                m_mem[(m_tail + n) % 64] = rls_pidx[j*6 +: 6];
                n++;
            end
        end
        if (m_free() + n > 64) m_err = 1;
        if (c > m_head - m_cmt) m_err = 1;
        if (recover) m_head = m_cmt + c;
        else if (!bsy) m_head = m_head + $countones(req);
        m_tail = m_tail + n;
        m_cmt  = m_cmt + c;
        @(posedge clock);
        #1;
        req = '0; rls = '0; rls_pidx = '0; cmt_cnt = '0; recover = 1'b0;
    endtask

    task automatic do_reset();
        req = '0; rls = '0; rls_pidx = '0; cmt_cnt = '0; recover = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (free_cnt !== 7'd32) begin n_errors++; $display("FAIL reset_async_free got %0d want 32", free_cnt); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pvld !== 4'b0000) begin n_errors++; $display("FAIL reset_pvld got %b want 0000", pvld); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (free_cnt !== 7'd32) begin n_errors++; $display("FAIL reset_free got %0d want 32", free_cnt); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_alloc4();
        do_reset();
        req = 4'b1111;
        #1;
        n_checks++;
        if (pvld !== 4'b1111) begin n_errors++; $display("FAIL alloc4_pvld got %b want 1111", pvld); end
        n_checks++;
        if (pidx !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
            n_errors++; $display("FAIL alloc4_pidx got %h want %h", pidx, {6'd35, 6'd34, 6'd33, 6'd32});
        end
        tick();
        n_checks++;
        if (free_cnt !== 7'd28) begin n_errors++; $display("FAIL alloc4_free got %0d want 28", free_cnt); end
    endtask

    task automatic test_sparse();
        do_reset();
        req = 4'b1010;
        #1;
        n_checks++;
        if (pvld !== 4'b1010) begin n_errors++; $display("FAIL sparse_pvld got %b want 1010", pvld); end
        n_checks++;
        if (pidx[11:6] !== 6'd32) begin n_errors++; $display("FAIL sparse_lane1 got %0d want 32", pidx[11:6]); end
        n_checks++;
        if (pidx[23:18] !== 6'd33) begin n_errors++; $display("FAIL sparse_lane3 got %0d want 33", pidx[23:18]); end
        tick();
        n_checks++;
        if (free_cnt !== 7'd30) begin n_errors++; $display("FAIL sparse_free got %0d want 30", free_cnt); end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = 4'b1111;
            #1;
            n_checks++;
            if (pvld !== 4'b1111) begin n_errors++; $display("FAIL exhaust_pvld cycle %0d got %b want 1111", c, pvld); end
            tick();
        end
        n_checks++;
        if (free_cnt !== 7'd0) begin n_errors++; $display("FAIL exhaust_free got %0d want 0", free_cnt); end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL exhaust_busy got %b want 1", busy); end
        req = 4'b1111;
        #1;
        n_checks++;
        if (pvld !== 4'b0000) begin n_errors++; $display("FAIL exhaust_nogrant got %b want 0000", pvld); end
        req = '0;
        rls = 4'b1111;
        rls_pidx = {6'd0, 6'd42, 6'd41, 6'd40};
        tick();
        n_checks++;
        if (free_cnt !== 7'd3) begin n_errors++; $display("FAIL exhaust_rls_free got %0d want 3", free_cnt); end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL exhaust_rls_busy got %b want 1", busy); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL exhaust_err got %b want 0", err); end
    endtask

    task automatic test_recover();
        do_reset();
        req = 4'b1111; tick();
        req = 4'b1111; tick();
        cmt_cnt = 3'd4; tick();
        recover = 1'b1;
        req = 4'b1111;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL recover_busy got %b want 1", busy); end
        n_checks++;
        if (pvld !== 4'b0000) begin n_errors++; $display("FAIL recover_pvld got %b want 0000", pvld); end
        tick();
        n_checks++;
        if (free_cnt !== 7'd28) begin n_errors++; $display("FAIL recover_free got %0d want 28", free_cnt); end
        req = 4'b1111;
        #1;
        n_checks++;
        if (pidx !== {6'd39, 6'd38, 6'd37, 6'd36}) begin
            n_errors++; $display("FAIL recover_pidx got %h want %h", pidx, {6'd39, 6'd38, 6'd37, 6'd36});
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            req = 4'b1111;
            rls = 4'b1111;
            for (int j = 0; j < 4; j++) rls_pidx[j*6 +: 6] = m_lane(j);
            #1;
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (pidx[j*6 +: 6] !== m_lane(j)) begin
                    n_errors++; $display("FAIL wrap_pidx cycle %0d lane %0d got %0d want %0d", c, j, pidx[j*6 +: 6], m_lane(j));
                end
            end
            tick();
            n_checks++;
            if (free_cnt !== 7'd32) begin n_errors++; $display("FAIL wrap_free cycle %0d got %0d want 32", c, free_cnt); end
        end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL wrap_err got %b want 0", err); end
    endtask

    task automatic test_err();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rls = 4'b1111;
            for (int j = 0; j < 4; j++) rls_pidx[j*6 +: 6] = 6'(4 * c + j + 1);
            tick();
        end
        n_checks++;
        if (free_cnt !== 7'd64) begin n_errors++; $display("FAIL err_full_free got %0d want 64", free_cnt); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_at_full got %b want 0", err); end
        rls = 4'b0001;
        rls_pidx = {18'd0, 6'd33};
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_overflow got %b want 1", err); end
        tick(); tick(); tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", err); end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_cleared got %b want 0", err); end
        cmt_cnt = 3'd1;
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_underflow got %b want 1", err); end
    endtask

    task automatic test_random();
        int maxc;
        int k;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req  = 4'($urandom);
            maxc = m_head - m_cmt;
            if (maxc > 4) maxc = 4;
            cmt_cnt = 3'($urandom_range(0, maxc));
            recover = ($urandom_range(0, 7) == 0) && (m_free() + (m_head - m_cmt) <= 64);
            if (m_free() <= 60) begin
                rls = 4'($urandom);
                for (int j = 0; j < 4; j++) rls_pidx[j*6 +: 6] = 6'($urandom);
            end
            #1;
            n_checks++;
            if (busy !== m_busy()) begin n_errors++; $display("FAIL rand_busy cycle %0d got %b want %b", c, busy, m_busy()); end
            n_checks++;
            if (pvld !== (m_busy() ? 4'b0000 : req)) begin
                n_errors++; $display("FAIL rand_pvld cycle %0d got %b want %b", c, pvld, m_busy() ? 4'b0000 : req);
            end
            n_checks++;
            if (int'(free_cnt) !== m_free()) begin n_errors++; $display("FAIL rand_free cycle %0d got %0d want %0d", c, free_cnt, m_free()); end
            n_checks++;
            if (err !== m_err) begin n_errors++; $display("FAIL rand_err cycle %0d got %b want %b", c, err, m_err); end
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (!m_busy()) begin
                        n_checks++;
                        if (pidx[i*6 +: 6] !== m_lane(k)) begin
                            n_errors++; $display("FAIL rand_pidx cycle %0d lane %0d got %0d want %0d", c, i, pidx[i*6 +: 6], m_lane(k));
                        end
                    end
                    k++;
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc4();
        test_sparse();
        test_exhaust();
        test_recover();
        test_wrap();
        test_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
